// File: rtl/pipeline_sequencer_if.sv
// Handshake bundle between the decode controller and the pipeline sequencer.
// The master side (controller / environment) drives the requests, the slave
// side (sequencer) returns enables, squash state and status.
interface pipeline_sequencer_if;
  logic        run;
  logic        stall_FETCH;
  logic        mul_req;
  logic        mul_done;
  logic        stall_EX;
  logic        pc_en;
  logic        ir_en;
  logic        mul_start;
  logic        wb_en;
  logic        mul_err;
  logic [31:0] instret;

  modport master (
    output run, stall_FETCH, mul_req, mul_done,
    input  stall_EX, pc_en, ir_en, mul_start, wb_en, mul_err, instret
  );

  modport slave (
    input  run, stall_FETCH, mul_req, mul_done,
    output stall_EX, pc_en, ir_en, mul_start, wb_en, mul_err, instret
  );
endinterface

// File: rtl/pipeline_sequencer.sv
// Pipeline sequencer for the two-stage RV32 core: owns the EX squash bit,
// PC / IR load enables, write-back qualification, the multi-cycle multiplier
// wait with timeout, halting at instruction boundaries and the retire counter.
module pipeline_sequencer #(
  parameter int unsigned MUL_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipeline_sequencer_if.slave  seq
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  // Last counter value allowed in MUL_WAIT before the multiply is abandoned.
  localparam logic [7:0] TMO_LAST = 8'(MUL_TIMEOUT - 32'd1);

  state_e      state_q, state_d;
  logic        stall_ex_q, stall_ex_d;
  logic [31:0] instret_q, instret_d;
  logic        mul_err_q, mul_err_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        pc_en_s;
  logic        ir_en_s;
  logic        wb_en_s;
  logic        mul_start_s;

  // Next-state and same-cycle enable decode from state, squash bit and inputs.
  always_comb begin
    state_d     = state_q;
    stall_ex_d  = stall_ex_q;
    instret_d   = instret_q;
    mul_err_d   = mul_err_q;
    cnt_d       = cnt_q;
    pc_en_s     = 1'b0;
    ir_en_s     = 1'b0;
    wb_en_s     = 1'b0;
    mul_start_s = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (!seq.run) begin
          // Halt at the boundary; the EX instruction re-executes on resume.
          state_d = ST_HALT;
        end else if (stall_ex_q) begin
          // Squashed slot: advance the pipe, write nothing back.
          pc_en_s    = 1'b1;
          ir_en_s    = 1'b1;
          stall_ex_d = 1'b0;
        end else if (seq.mul_req) begin
          mul_start_s = 1'b1;
          cnt_d       = 8'd0;
          state_d     = ST_WAIT;
        end else begin
          pc_en_s    = 1'b1;
          ir_en_s    = 1'b1;
          wb_en_s    = 1'b1;
          stall_ex_d = seq.stall_FETCH;
          instret_d  = instret_q + 32'd1;
        end
      end

      ST_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (seq.mul_done) begin
          pc_en_s    = 1'b1;
          ir_en_s    = 1'b1;
          wb_en_s    = 1'b1;
          stall_ex_d = 1'b0;
          instret_d  = instret_q + 32'd1;
          state_d    = seq.run ? ST_RUN : ST_HALT;
        end else if (cnt_q == TMO_LAST) begin
          // Multiplier never answered: drop the instruction and move on.
          pc_en_s    = 1'b1;
          ir_en_s    = 1'b1;
          stall_ex_d = 1'b0;
          mul_err_d  = 1'b1;
          state_d    = seq.run ? ST_RUN : ST_HALT;
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_HALT: begin
        if (seq.run) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_HALT;
        end
      end

      default: begin
        // Unreachable encoding: recover to a squashed RUN slot.
        state_d    = ST_RUN;
        stall_ex_d = 1'b1;
      end
    endcase
  end

  // State registers with asynchronous return to the reset values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      stall_ex_q <= 1'b1;
      instret_q  <= 32'd0;
      mul_err_q  <= 1'b0;
      cnt_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      stall_ex_q <= stall_ex_d;
      instret_q  <= instret_d;
      mul_err_q  <= mul_err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign seq.stall_EX  = stall_ex_q;
  assign seq.instret   = instret_q;
  assign seq.mul_err   = mul_err_q;
  assign seq.pc_en     = pc_en_s;
  assign seq.ir_en     = ir_en_s;
  assign seq.wb_en     = wb_en_s;
  assign seq.mul_start = mul_start_s;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Randomized scoreboard bench for pipeline_sequencer: a cycle-level reference
// model predicts each cycle's outputs, a monitor compares them to the DUT.
module tb_pipeline_sequencer;
  localparam int TMO    = 4;
  localparam int M_RUN  = 0;
  localparam int M_WAIT = 1;
  localparam int M_HALT = 2;

  logic clk = 1'b0;
  logic rst_n;

  pipeline_sequencer_if intf();

  pipeline_sequencer #(.MUL_TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .seq   (intf.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pc_en;
    logic        ir_en;
    logic        wb_en;
    logic        mul_start;
    logic        stall_ex;
    logic        mul_err;
    logic [31:0] instret;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state
  int          m_mode;
  bit          m_squash;
  logic [31:0] m_ret;
  bit          m_err;
  int          m_waited;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode   = M_RUN;
    m_squash = 1'b1;
    m_ret    = 32'd0;
    m_err    = 1'b0;
    m_waited = 0;
  endtask

  // Called at a falling edge: apply inputs, predict this cycle, queue the prediction.
  task automatic drive_cycle(input bit r, input bit sf, input bit mr, input bit md);
    exp_t e;
    intf.run         = r;
    intf.stall_FETCH = sf;
    intf.mul_req     = mr;
    intf.mul_done    = md;
    e.stall_ex  = m_squash;
    e.instret   = m_ret;
    e.mul_err   = m_err;
    e.pc_en     = 1'b0;
    e.ir_en     = 1'b0;
    e.wb_en     = 1'b0;
    e.mul_start = 1'b0;
    case (m_mode)
      M_RUN: begin
        if (!r) begin
          m_mode = M_HALT;
        end else if (m_squash) begin
          e.pc_en = 1'b1; e.ir_en = 1'b1;
          m_squash = 1'b0;
        end else if (mr) begin
          e.mul_start = 1'b1;
          m_waited = 0;
          m_mode = M_WAIT;
        end else begin
          e.pc_en = 1'b1; e.ir_en = 1'b1; e.wb_en = 1'b1;
          m_squash = sf;
          m_ret = m_ret + 32'd1;
        end
      end
      M_WAIT: begin
        m_waited++;
        if (md) begin
          e.pc_en = 1'b1; e.ir_en = 1'b1; e.wb_en = 1'b1;
          m_squash = 1'b0;
          m_ret = m_ret + 32'd1;
          m_mode = r ? M_RUN : M_HALT;
        end else if (m_waited == TMO) begin
          e.pc_en = 1'b1; e.ir_en = 1'b1;
          m_squash = 1'b0;
          m_err = 1'b1;
          m_mode = r ? M_RUN : M_HALT;
        end
      end
      default: begin
        if (r) m_mode = M_RUN;
      end
    endcase
    exp_q.push_back(e);
  endtask

  // Monitor: compare outputs a few time units after each falling edge.
  always @(negedge clk) begin
    #3;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("pc_en",     {31'd0, intf.pc_en},     {31'd0, mon_e.pc_en});
      chk("ir_en",     {31'd0, intf.ir_en},     {31'd0, mon_e.ir_en});
      chk("wb_en",     {31'd0, intf.wb_en},     {31'd0, mon_e.wb_en});
      chk("mul_start", {31'd0, intf.mul_start}, {31'd0, mon_e.mul_start});
      chk("stall_EX",  {31'd0, intf.stall_EX},  {31'd0, mon_e.stall_ex});
      chk("mul_err",   {31'd0, intf.mul_err},   {31'd0, mon_e.mul_err});
      chk("instret",   intf.instret,            mon_e.instret);
    end
  end

  initial begin
    int guard;
    rst_n            = 1'b0;
    intf.run         = 1'b0;
    intf.stall_FETCH = 1'b0;
    intf.mul_req     = 1'b0;
    intf.mul_done    = 1'b0;
    model_reset();

    // Reset state with run low, then with run high.
    #12;
    chk("rst_stall_EX",  {31'd0, intf.stall_EX},  32'd1);
    chk("rst_instret",   intf.instret,            32'd0);
    chk("rst_mul_err",   {31'd0, intf.mul_err},   32'd0);
    chk("rst_pc_en_r0",  {31'd0, intf.pc_en},     32'd0);
    chk("rst_wb_en",     {31'd0, intf.wb_en},     32'd0);
    chk("rst_mul_start", {31'd0, intf.mul_start}, 32'd0);
    intf.run = 1'b1;
    #1;
    chk("rst_pc_en_r1",  {31'd0, intf.pc_en},     32'd1);
    chk("rst_ir_en_r1",  {31'd0, intf.ir_en},     32'd1);

    // Bubble then three plain instructions.
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    end

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      drive_cycle($urandom_range(0, 15) != 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 2) == 0);
    end

    // Steer to a live RUN slot, then preset instret to all ones.
    guard = 0;
    while (!(m_mode == M_RUN && !m_squash) && guard < 12) begin
      @(negedge clk);
      drive_cycle(1'b1, 1'b0, 1'b0, 1'b1);
      guard++;
    end
    chk("steer_to_run", {31'd0, (m_mode == M_RUN && !m_squash)}, 32'd1);
    @(posedge clk);
    #1;
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    m_ret = 32'hFFFF_FFFF;
    @(negedge clk);
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    // Start a multiply and sit in the wait.
    @(negedge clk);
    drive_cycle(1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of the wait.
    #4;
    rst_n = 1'b0;
    #1;
    chk("async_stall_EX", {31'd0, intf.stall_EX}, 32'd1);
    chk("async_instret",  intf.instret,           32'd0);
    chk("async_mul_err",  {31'd0, intf.mul_err},  32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      drive_cycle($urandom_range(0, 7) != 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 2) == 0);
    end

    @(negedge clk);
    #5;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Sequencing block for the two-stage (FETCH / EX-WB) RV32 core: owns the `stall_EX` squash register, PC and instruction-register enables, and write-back qualification. It stalls the pipeline around the multi-cycle multiplier and halts at instruction boundaries on request. It also keeps a retired-instruction counter. It sits between the combinational decode controller (which produces `stall_FETCH` and the raw `regwrite`/`gpio_we`) and the PC, instruction register, regfile and GPIO registers.

## Interface
- `MUL_TIMEOUT`, default 15: maximum cycles spent in MUL_WAIT before abort; range 1..255.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  1 = execute; 0 = halt at the next instruction boundary.
- `stall_FETCH`  in  1  from the controller; 1 = control transfer taken by the EX instruction. Valid only when `stall_EX`=0; otherwise ignored.
- `mul_req`  in  1  EX instruction is mul/mulh/mulhu (decoded opcode 0110011, funct7 0000001).
- `mul_done`  in  1  multiplier result valid; single-cycle pulse.
- `stall_EX`  out  1  registered; 1 = the EX instruction is squashed (no write-back, no branch).
- `pc_en`  out  1  PC register load enable.
- `ir_en`  out  1  FETCH→EX instruction register load enable.
- `mul_start`  out  1  one-cycle start pulse to the multiplier.
- `wb_en`  out  1  qualifies `regwrite` and `gpio_we`; the regfile and GPIO write only when `wb_en`=1.
- `mul_err`  out  1  sticky; set on multiplier timeout, cleared only by reset.
- `instret`  out  32  count of retired (written-back, unsquashed) instructions.

## Operation
- FSM states are RUN, MUL_WAIT and HALT. Reset state is RUN.
- Define `live` = ~`stall_EX`.
- **RUN, `run`=1, `live`, `mul_req`=0**
  - `pc_en`=`ir_en`=`wb_en`=1.
  - `stall_EX`←`stall_FETCH`, so the fetched instruction after a taken jal/jalr/branch is squashed.
  - `instret`++.
- **RUN, `run`=1, `live`, `mul_req`=1**
  - `mul_start`=1 this cycle; `pc_en`=`ir_en`=`wb_en`=0.
  - Load the timeout counter with 0, then →MUL_WAIT.
- **RUN, `run`=1, `stall_EX`=1**
  - `pc_en`=`ir_en`=1, `wb_en`=0.
  - `stall_EX`←0; `mul_req` and `stall_FETCH` are ignored.
- **RUN, `run`=0**
  - →HALT; all enables are 0 and `stall_EX` holds.
  - The EX instruction is not retired in this cycle; it re-executes on resume.
- **MUL_WAIT**
  - `pc_en`=`ir_en`=0; the counter increments every cycle.
  - On `mul_done`=1: `wb_en`=1, `pc_en`=`ir_en`=1, `stall_EX`←0, `instret`++. Next state is RUN if `run`=1, else HALT.
  - On counter = `MUL_TIMEOUT`−1 with no `mul_done`: `mul_err`←1, `wb_en`=0, `pc_en`=`ir_en`=1, `stall_EX`←0. Next state is RUN/HALT as above. The instruction is dropped and not counted.
  - `run`=0 during MUL_WAIT does not abort; the multiply completes first.
- **HALT**
  - All enables and `mul_start` are 0; state holds.
  - `run`=1 →RUN next cycle. There is no enable in the transition cycle.
- `mul_done` outside MUL_WAIT is ignored.
- `instret` wraps 0xFFFFFFFF→0.
- Timeout counter is 8 bits.

## Timing
- Reset values:
  - state RUN, `stall_EX`=1 (first EX slot holds no valid instruction), `instret`=0, `mul_err`=0, counter 0.
  - Combinational outputs follow from the reset state: `mul_start`=0, `wb_en`=0, and `pc_en`=`ir_en`=`run`.
- `pc_en`, `ir_en`, `wb_en` and `mul_start` are combinational from state, `stall_EX` and inputs. They are valid in the same cycle as the EX instruction.
- `stall_EX`, `instret` and `mul_err` update on the clock edge that ends the cycle.
- Taken control transfer costs 1 bubble cycle.
- A multiply costs 1 + N cycles, where `mul_done` arrives N cycles after `mul_start` (N ≥ 1).
- Reset asserted mid-MUL_WAIT or HALT returns immediately (asynchronously) to reset values. `mul_err` is cleared.

## Test plan
- Reset, `run`=1, three addi with no branch → `stall_EX`=1 in cycle 0. `wb_en`=0,1,1,1 in cycles 0-3. `instret`=3 after cycle 3.
- jal in EX with `stall_FETCH`=1 → `wb_en`=1 that cycle; next cycle `stall_EX`=1, `wb_en`=0, `pc_en`=1; the following cycle `stall_EX`=0. `instret` counts 1 for the pair.
- mul in EX, `mul_done` 3 cycles after `mul_start` → `mul_start` high for exactly 1 cycle. `pc_en`=0 for 3 cycles. `wb_en`=1 in the done cycle. `instret`+1.
- mul with no `mul_done`, `MUL_TIMEOUT`=4 → `mul_err`=1 after cycle 4 of the wait. `wb_en` is never 1. Pipeline resumes in RUN. `instret` is unchanged.
- `run`→0 during MUL_WAIT, `mul_done` 2 cycles later → write-back occurs, then HALT with all enables 0. `run`→1 gives RUN one cycle later.
- `instret` preset to 0xFFFFFFFF via force, then one retire → 0. Assert `rst_n`=0 mid-MUL_WAIT → `stall_EX`=1, `instret`=0, `mul_err`=0 without waiting for a clock edge.
